// File: rtl/reg_file_arbiter.sv
// rtl/reg_file_arbiter.sv - register file arbiter between the core and the debug port
// Core accesses pass through; one debug word access is slotted into an idle port cycle.
module reg_file_arbiter #(
  parameter int BYTE_ADDR_WIDTH = 7,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_rd_en0,
  input  logic [BYTE_ADDR_WIDTH-3:0] core_rd_addr0,
  input  logic                       core_rd_en1,
  input  logic [BYTE_ADDR_WIDTH-3:0] core_rd_addr1,
  input  logic                       core_wr_en,
  input  logic [BYTE_ADDR_WIDTH-3:0] core_wr_addr,
  input  logic [3:0]                 core_byte_en,
  input  logic [31:0]                core_wr_data,
  output logic                       core_stall,
  input  logic                       dbg_req,
  input  logic                       dbg_we,
  input  logic [BYTE_ADDR_WIDTH-3:0] dbg_addr,
  input  logic [31:0]                dbg_wdata,
  output logic                       dbg_ready,
  output logic                       dbg_ack,
  output logic [31:0]                dbg_rdata,
  output logic                       rf_rd_en0,
  output logic [BYTE_ADDR_WIDTH-3:0] rf_rd_addr0,
  output logic                       rf_rd_en1,
  output logic [BYTE_ADDR_WIDTH-3:0] rf_rd_addr1,
  output logic                       rf_wr_en,
  output logic [BYTE_ADDR_WIDTH-3:0] rf_wr_addr,
  output logic [3:0]                 rf_byte_en,
  output logic [31:0]                rf_wr_data,
  input  logic [31:0]                rf_rd_data0
);

  localparam int AW = BYTE_ADDR_WIDTH - 2;
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    CAPT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            req_we_q, req_we_d;
  logic [AW-1:0]   req_addr_q, req_addr_d;
  logic [31:0]     req_wdata_q, req_wdata_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            force_grant;
  logic            wr_grant;
  logic            rd_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    force_grant = 1'b0;
    wr_grant    = 1'b0;
    rd_grant    = 1'b0;
    dbg_ready   = 1'b0;
    core_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        dbg_ready = 1'b1;
        if (dbg_req) begin
          req_we_d    = dbg_we;
          req_addr_d  = dbg_addr;
          req_wdata_d = dbg_wdata;
          wait_cnt_d  = '0;
          state_d     = PEND;
        end
      end
      PEND: begin
        force_grant = (wait_cnt_q == LIMIT);
        core_stall  = force_grant;
        if (req_we_q) begin
          if (!core_wr_en || force_grant) begin
            wr_grant = 1'b1;
            ack_d    = 1'b1;
            state_d  = IDLE;
          end
        end else if (!core_rd_en0 || force_grant) begin
          rd_grant = 1'b1;
          state_d  = CAPT;
        end
        if (!wr_grant && !rd_grant && (wait_cnt_q != LIMIT)) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      CAPT: begin
        // rf read data from the grant cycle is valid now
        rdata_d = rf_rd_data0;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic          wr_sel_en;
  logic [AW-1:0] wr_sel_addr;

  assign rf_rd_en0   = rd_grant ? 1'b1 : core_rd_en0;
  assign rf_rd_addr0 = rd_grant ? req_addr_q : core_rd_addr0;
  assign rf_rd_en1   = core_rd_en1;
  assign rf_rd_addr1 = core_rd_addr1;

  assign wr_sel_en   = wr_grant ? 1'b1 : core_wr_en;
  assign wr_sel_addr = wr_grant ? req_addr_q : core_wr_addr;
  // x0 is hardwired zero: no write to word 0 ever reaches the file
  assign rf_wr_en    = wr_sel_en && (wr_sel_addr != '0);
  assign rf_wr_addr  = wr_sel_addr;
  assign rf_byte_en  = wr_grant ? 4'hF : core_byte_en;
  assign rf_wr_data  = wr_grant ? req_wdata_q : core_wr_data;

  assign dbg_ack     = ack_q;
  assign dbg_rdata   = rdata_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb/tb_reg_file_arbiter.sv - scoreboard bench for reg_file_arbiter
// Includes a behavioural register file with 1-cycle registered read on port 0.
module tb_reg_file_arbiter;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_rd_en0, core_rd_en1, core_wr_en;
  logic [AW-1:0] core_rd_addr0, core_rd_addr1, core_wr_addr;
  logic [3:0]    core_byte_en;
  logic [31:0]   core_wr_data;
  logic          core_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;
  logic          dbg_ready, dbg_ack;
  logic [31:0]   dbg_rdata;
  logic          rf_rd_en0, rf_rd_en1, rf_wr_en;
  logic [AW-1:0] rf_rd_addr0, rf_rd_addr1, rf_wr_addr;
  logic [3:0]    rf_byte_en;
  logic [31:0]   rf_wr_data;
  logic [31:0]   rf_rd_data0;

  reg_file_arbiter #(.BYTE_ADDR_WIDTH(7), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .core_rd_en0(core_rd_en0), .core_rd_addr0(core_rd_addr0),
    .core_rd_en1(core_rd_en1), .core_rd_addr1(core_rd_addr1),
    .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr),
    .core_byte_en(core_byte_en), .core_wr_data(core_wr_data),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_rd_en0(rf_rd_en0), .rf_rd_addr0(rf_rd_addr0),
    .rf_rd_en1(rf_rd_en1), .rf_rd_addr1(rf_rd_addr1),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_byte_en(rf_byte_en), .rf_wr_data(rf_wr_data),
    .rf_rd_data0(rf_rd_data0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      rf_rd_data0 <= '0;
    end else begin
      if (rf_rd_en0) rf_rd_data0 <= mem[rf_rd_addr0];
      if (rf_wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (rf_byte_en[b]) mem[rf_wr_addr][8*b +: 8] <= rf_wr_data[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   total = 0;
  int   bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one debug request for a single cycle; optionally record the expected ack.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic do_push, input logic [31:0] exp_rd, input int lat);
    exp_t e;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wd;
    @(negedge clk);
    check_eq("dbg_ready_at_issue", 32'(dbg_ready), 32'd1);
    if (do_push) begin
      e.we      = we;
      e.rdata   = exp_rd;
      e.ack_cyc = cyc + lat;
      sb.push_back(e);
    end
    tick();
    dbg_req = 1'b0;
  endtask

  initial begin
    int   n;
    int   acc_cyc;
    exp_t e6;

    fork
      forever begin
        @(negedge clk);
        if (dbg_ack) begin
          check_eq("ack_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            got = sb.pop_front();
            check_eq("ack_cycle", cyc, got.ack_cyc);
            if (!got.we) check_eq("dbg_rdata", dbg_rdata, got.rdata);
          end
        end
        if (rf_wr_en) check_eq("x0_write_blocked", 32'(rf_wr_addr != '0), 32'd1);
      end
    join_none

    rst = 1'b1;
    core_rd_en0 = 0; core_rd_en1 = 0; core_wr_en = 0;
    core_rd_addr0 = '0; core_rd_addr1 = '0; core_wr_addr = '0;
    core_byte_en = '0; core_wr_data = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_ready", 32'(dbg_ready), 32'd1);
    check_eq("rst_ack", 32'(dbg_ack), 32'd0);
    check_eq("rst_rdata", dbg_rdata, 32'd0);
    check_eq("rst_stall", 32'(core_stall), 32'd0);
    tick();
    rst = 1'b0;

    // core passthrough, preloads x7
    core_rd_en0 = 1; core_rd_addr0 = 5'd4; core_rd_en1 = 1; core_rd_addr1 = 5'd6;
    core_wr_en = 1; core_wr_addr = 5'd7; core_byte_en = 4'hF; core_wr_data = 32'hCAFE_0007;
    @(negedge clk);
    check_eq("pt_rd_addr0", 32'(rf_rd_addr0), 32'd4);
    check_eq("pt_rd_addr1", 32'(rf_rd_addr1), 32'd6);
    check_eq("pt_rd_en1", 32'(rf_rd_en1), 32'd1);
    check_eq("pt_wr_en", 32'(rf_wr_en), 32'd1);
    check_eq("pt_wr_addr", 32'(rf_wr_addr), 32'd7);
    check_eq("pt_wr_data", rf_wr_data, 32'hCAFE_0007);
    tick();
    core_rd_en0 = 0; core_rd_en1 = 0; core_wr_en = 0;

    // 1: debug write x5 with the core idle, then read it back
    issue(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'd0, 2);
    @(negedge clk);
    check_eq("t1_wr_en", 32'(rf_wr_en), 32'd1);
    check_eq("t1_wr_addr", 32'(rf_wr_addr), 32'd5);
    check_eq("t1_byte_en", 32'(rf_byte_en), 32'hF);
    check_eq("t1_wr_data", rf_wr_data, 32'hDEAD_BEEF);
    check_eq("t1_ready_pend", 32'(dbg_ready), 32'd0);
    check_eq("t1_stall", 32'(core_stall), 32'd0);
    repeat (2) tick();
    issue(1'b0, 5'd5, 32'd0, 1'b1, 32'hDEAD_BEEF, 3);
    @(negedge clk);
    check_eq("t1_rd_en0", 32'(rf_rd_en0), 32'd1);
    check_eq("t1_rd_addr0", 32'(rf_rd_addr0), 32'd5);
    repeat (4) tick();
    @(negedge clk);
    check_eq("t1_rdata_hold", dbg_rdata, 32'hDEAD_BEEF);
    tick();

    // 2: core write port busy continuously -> forced grant after 8 waits
    core_wr_en = 1; core_wr_addr = 5'd9; core_byte_en = 4'hF; core_wr_data = 32'h1111_1111;
    issue(1'b1, 5'd3, 32'h3333_3333, 1'b1, 32'd0, 10);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check_eq("t2_stall", 32'(core_stall), (i == 9) ? 32'd1 : 32'd0);
      check_eq("t2_wr_addr", 32'(rf_wr_addr), (i == 9) ? 32'd3 : 32'd9);
      tick();
    end
    @(negedge clk);
    check_eq("t2_stall_after", 32'(core_stall), 32'd0);
    check_eq("t2_core_wr_back", 32'(rf_wr_addr), 32'd9);
    tick();
    core_wr_en = 0;
    issue(1'b0, 5'd3, 32'd0, 1'b1, 32'h3333_3333, 3);
    repeat (4) tick();

    // 3: x0 writes from both sides are dropped
    core_wr_en = 1; core_wr_addr = 5'd0; core_wr_data = 32'h1234;
    @(negedge clk);
    check_eq("t3_core_x0", 32'(rf_wr_en), 32'd0);
    tick();
    core_wr_en = 0;
    issue(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 2);
    @(negedge clk);
    check_eq("t3_dbg_x0", 32'(rf_wr_en), 32'd0);
    repeat (2) tick();
    issue(1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 3);
    repeat (4) tick();

    // 4: debug read x7 while core channel 0 goes 1,1,0
    core_rd_addr0 = 5'd2;
    issue(1'b0, 5'd7, 32'd0, 1'b1, 32'hCAFE_0007, 5);
    core_rd_en0 = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("t4_core_rd_addr", 32'(rf_rd_addr0), 32'd2);
      check_eq("t4_core_rd_en", 32'(rf_rd_en0), 32'd1);
      tick();
    end
    core_rd_en0 = 0;
    @(negedge clk);
    check_eq("t4_grant_addr", 32'(rf_rd_addr0), 32'd7);
    check_eq("t4_grant_en", 32'(rf_rd_en0), 32'd1);
    check_eq("t4_stall", 32'(core_stall), 32'd0);
    tick();
    core_rd_en0 = 1;
    @(negedge clk);
    check_eq("t4_capt_passthru", 32'(rf_rd_addr0), 32'd2);
    tick();
    core_rd_en0 = 0;
    repeat (4) tick();

    // 5a: reset while PEND
    core_wr_en = 1; core_wr_addr = 5'd9;
    issue(1'b1, 5'd4, 32'h5555_5555, 1'b0, 32'd0, 0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("t5a_ready", 32'(dbg_ready), 32'd1);
    check_eq("t5a_ack", 32'(dbg_ack), 32'd0);
    check_eq("t5a_rdata", dbg_rdata, 32'd0);
    tick();
    rst = 1'b0; core_wr_en = 0;
    repeat (4) tick();

    // 5b: reset while CAPT
    issue(1'b1, 5'd5, 32'h5A5A_5A5A, 1'b1, 32'd0, 2);
    repeat (2) tick();
    issue(1'b0, 5'd5, 32'd0, 1'b1, 32'h5A5A_5A5A, 3);
    repeat (4) tick();
    issue(1'b0, 5'd5, 32'd0, 1'b0, 32'd0, 0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("t5b_ready", 32'(dbg_ready), 32'd1);
    check_eq("t5b_ack", 32'(dbg_ack), 32'd0);
    check_eq("t5b_rdata", dbg_rdata, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // 6: dbg_req held high across three writes
    n = 0;
    acc_cyc = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd10; dbg_wdata = 32'h6000_0010;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (dbg_ready) begin
        if (n > 0) check_eq("t6_accept_gap", cyc - acc_cyc, 32'd2);
        acc_cyc    = cyc;
        e6.we      = 1'b1;
        e6.rdata   = '0;
        e6.ack_cyc = cyc + 2;
        sb.push_back(e6);
        n++;
        tick();
        dbg_addr  = AW'(10 + n);
        dbg_wdata = 32'h6000_0010 + n;
      end else begin
        tick();
      end
    end
    dbg_req = 0;
    check_eq("t6_accepts", n, 32'd3);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, AW'(10 + i), 32'd0, 1'b1, 32'h6000_0010 + i, 3);
      repeat (4) tick();
    end

    repeat (5) tick();
    check_eq("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
